// File: rtl/amp_sequencer.sv
// Multi-channel amplifier power sequencer: enable, config request, per-channel unmute,
// orderly mute-before-shutdown, and fault handling with bounded auto-retry and lockout.
// Every output is registered. A timed state loaded with N lasts exactly N cycles.
module amp_sequencer #(
  parameter int N_CH          = 2,
  parameter int TIMER_W       = 16,
  parameter int ENABLE_CYCLES = 1000,
  parameter int CFG_TIMEOUT   = 5000,
  parameter int RETRY_CYCLES  = 20000,
  parameter int MUTE_CYCLES   = 500,
  parameter int MAX_RETRY     = 3,
  parameter int RW            = 2
) (
  input  logic            clk_in,
  input  logic            reset_in,
  input  logic            start_in,
  input  logic            audio_locked_in,
  input  logic [N_CH-1:0] nerror_in,
  input  logic [N_CH-1:0] ch_mask_in,
  input  logic            cfg_ack_in,
  output logic            nenable_out,
  output logic [N_CH-1:0] nmute_out,
  output logic            send_config_out,
  output logic            fault_out,
  output logic            lockout_out,
  output logic [RW-1:0]   retry_cnt_out,
  output logic [2:0]      state_out
);

  typedef enum logic [2:0] {
    INIT        = 3'd0,
    ENABLE_WAIT = 3'd1,
    SEND_CFG    = 3'd2,
    RUN         = 3'd3,
    FAULT       = 3'd4,
    RETRY_WAIT  = 3'd5,
    LOCKOUT     = 3'd6,
    SHUTDOWN    = 3'd7
  } state_t;

  // The timer holds "cycles remaining after this one", so each load is N-1.
  localparam logic [TIMER_W-1:0] ENABLE_LOAD = TIMER_W'(ENABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] CFG_LOAD    = TIMER_W'(CFG_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] RETRY_LOAD  = TIMER_W'(RETRY_CYCLES - 1);
  localparam logic [TIMER_W-1:0] MUTE_LOAD   = TIMER_W'(MUTE_CYCLES - 1);
  localparam logic [RW-1:0]      RETRY_MAX   = RW'(MAX_RETRY);

  state_t             state, next_state;
  logic [TIMER_W-1:0] timer, next_timer;
  logic [RW-1:0]      retry_cnt, next_retry;
  logic               timer_zero;
  logic               ch_fault;

  logic               next_nenable;
  logic [N_CH-1:0]    next_nmute;
  logic               next_send_config;
  logic               next_fault;
  logic               next_lockout;

  assign timer_zero = (timer == '0);
  // Faults on channels that are masked out are not our concern.
  assign ch_fault   = |(ch_mask_in & ~nerror_in);

  // State register plus the registered copies of every output.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state           <= INIT;
      timer           <= '0;
      retry_cnt       <= '0;
      nenable_out     <= 1'b1;
      nmute_out       <= '0;
      send_config_out <= 1'b0;
      fault_out       <= 1'b0;
      lockout_out     <= 1'b0;
    end else begin
      state           <= next_state;
      timer           <= next_timer;
      retry_cnt       <= next_retry;
      nenable_out     <= next_nenable;
      nmute_out       <= next_nmute;
      send_config_out <= next_send_config;
      fault_out       <= next_fault;
      lockout_out     <= next_lockout;
    end
  end

  // Next state, timer reload/countdown and retry accounting.
  always_comb begin
    next_state = state;
    next_timer = timer_zero ? timer : timer - 1'b1;
    next_retry = retry_cnt;
    case (state)
      INIT: begin
        if (start_in) begin
          next_state = ENABLE_WAIT;
          next_timer = ENABLE_LOAD;
        end
      end
      ENABLE_WAIT: begin
        if (!start_in) begin
          next_state = SHUTDOWN;
          next_timer = MUTE_LOAD;
        end else if (timer_zero) begin
          next_state = SEND_CFG;
          next_timer = CFG_LOAD;
        end
      end
      SEND_CFG: begin
        // An ack arriving on the timeout cycle still counts.
        if (!start_in) begin
          next_state = SHUTDOWN;
          next_timer = MUTE_LOAD;
        end else if (cfg_ack_in) begin
          next_state = RUN;
        end else if (timer_zero) begin
          next_state = FAULT;
        end
      end
      RUN: begin
        if (ch_fault) begin
          next_state = FAULT;
        end else if (!start_in) begin
          next_state = SHUTDOWN;
          next_timer = MUTE_LOAD;
        end
      end
      SHUTDOWN: begin
        if (timer_zero) next_state = INIT;
      end
      FAULT: begin
        if (retry_cnt == RETRY_MAX) begin
          next_state = LOCKOUT;
        end else begin
          next_state = RETRY_WAIT;
          next_timer = RETRY_LOAD;
          next_retry = retry_cnt + 1'b1;
        end
      end
      RETRY_WAIT: begin
        if (!start_in) begin
          next_state = INIT;
        end else if (timer_zero) begin
          next_state = ENABLE_WAIT;
          next_timer = ENABLE_LOAD;
        end
      end
      LOCKOUT: begin
        if (!start_in) next_state = INIT;
      end
      default: next_state = INIT;
    endcase
    // Retries are forgotten whenever the sequence returns to INIT.
    if (next_state == INIT) next_retry = '0;
  end

  // Output values for the state being entered; unmute only while staying in RUN.
  always_comb begin
    next_nenable     = 1'b1;
    next_nmute       = '0;
    next_send_config = 1'b0;
    next_fault       = 1'b0;
    next_lockout     = 1'b0;
    case (next_state)
      ENABLE_WAIT: next_nenable = 1'b0;
      SEND_CFG: begin
        next_nenable     = 1'b0;
        next_send_config = 1'b1;
      end
      RUN: begin
        next_nenable = 1'b0;
        if (state == RUN) next_nmute = {N_CH{audio_locked_in}} & ch_mask_in & nerror_in;
      end
      SHUTDOWN:   next_nenable = 1'b0;
      FAULT:      next_fault   = 1'b1;
      RETRY_WAIT: next_fault   = 1'b1;
      LOCKOUT:    next_lockout = 1'b1;
      default:    next_nenable = 1'b1;
    endcase
  end

  assign retry_cnt_out = retry_cnt;
  assign state_out     = state;

endmodule

// File: tb/tb_amp_sequencer.sv
// Randomised plus directed bench for amp_sequencer with a scoreboard:
// the driver steps a reference model per cycle and queues the expected outputs,
// a monitor pops and compares them after every clock edge.
module tb_amp_sequencer;

  localparam int N_CH = 2;
  localparam int EN_C = 4;
  localparam int CFG_C = 8;
  localparam int RET_C = 6;
  localparam int MUTE_C = 5;
  localparam int MAXR = 2;
  localparam int RW = 2;

  // Reference model phase names (values double as the expected state_out code)
  localparam int P_INIT = 0, P_EW = 1, P_CFG = 2, P_RUN = 3, P_FAULT = 4, P_RWAIT = 5, P_LOCK = 6, P_SD = 7;

  typedef struct packed {
    logic            nen;
    logic [N_CH-1:0] nmute;
    logic            cfg;
    logic            flt;
    logic            lck;
    logic [RW-1:0]   retry;
    logic [2:0]      st;
  } obs_t;

  logic clk_in = 1'b0;
  logic reset_in = 1'b1, start_in = 1'b0, audio_locked_in = 1'b0, cfg_ack_in = 1'b0;
  logic [N_CH-1:0] nerror_in = '1, ch_mask_in = '1;
  logic nenable_out, send_config_out, fault_out, lockout_out;
  logic [N_CH-1:0] nmute_out;
  logic [RW-1:0] retry_cnt_out;
  logic [2:0] state_out;

  always #5 clk_in = ~clk_in;

  amp_sequencer #(
    .N_CH(N_CH), .TIMER_W(16), .ENABLE_CYCLES(EN_C), .CFG_TIMEOUT(CFG_C),
    .RETRY_CYCLES(RET_C), .MUTE_CYCLES(MUTE_C), .MAX_RETRY(MAXR), .RW(RW)
  ) dut (
    .clk_in(clk_in), .reset_in(reset_in), .start_in(start_in),
    .audio_locked_in(audio_locked_in), .nerror_in(nerror_in), .ch_mask_in(ch_mask_in),
    .cfg_ack_in(cfg_ack_in), .nenable_out(nenable_out), .nmute_out(nmute_out),
    .send_config_out(send_config_out), .fault_out(fault_out), .lockout_out(lockout_out),
    .retry_cnt_out(retry_cnt_out), .state_out(state_out)
  );

  obs_t sb[$];
  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: phase, cycles spent in it (1 = first cycle), retries used
  int m_phase = P_INIT;
  int m_elapsed = 0;
  int m_retry = 0;

  // Stimulus to apply at the next tick (ack is a one-shot)
  logic r_rst = 1'b1, r_start = 1'b0, r_lock = 1'b1, r_ack = 1'b0;
  logic [N_CH-1:0] r_nerr = '1, r_mask = '1;

  function automatic obs_t model_step(input logic rst, input logic st, input logic lk,
                                      input logic [N_CH-1:0] ne, input logic [N_CH-1:0] mk,
                                      input logic ack);
    obs_t e;
    int nxt;
    int bad;
    e = '0;
    e.nen = 1'b1;
    if (rst) begin
      m_phase = P_INIT;
      m_elapsed = 0;
      m_retry = 0;
      return e;
    end
    nxt = m_phase;
    bad = 0;
    for (int i = 0; i < N_CH; i++) if (mk[i] && !ne[i]) bad = 1;
    case (m_phase)
      P_INIT:  if (st) nxt = P_EW;
      P_EW:    if (!st) nxt = P_SD; else if (m_elapsed == EN_C) nxt = P_CFG;
      P_CFG:   if (!st) nxt = P_SD; else if (ack) nxt = P_RUN; else if (m_elapsed == CFG_C) nxt = P_FAULT;
      P_RUN: begin
        if (bad != 0) nxt = P_FAULT;
        else if (!st) nxt = P_SD;
        else for (int i = 0; i < N_CH; i++) e.nmute[i] = lk && mk[i] && ne[i];
      end
      P_SD:    if (m_elapsed == MUTE_C) nxt = P_INIT;
      P_FAULT: begin
        if (m_retry == MAXR) nxt = P_LOCK;
        else begin
          nxt = P_RWAIT;
          m_retry = m_retry + 1;
        end
      end
      P_RWAIT: if (!st) nxt = P_INIT; else if (m_elapsed == RET_C) nxt = P_EW;
      P_LOCK:  if (!st) nxt = P_INIT;
      default: nxt = P_INIT;
    endcase
    if (nxt != m_phase) m_elapsed = 1;
    else m_elapsed = m_elapsed + 1;
    m_phase = nxt;
    if (m_phase == P_INIT) m_retry = 0;
    e.nen   = !(m_phase == P_EW || m_phase == P_CFG || m_phase == P_RUN || m_phase == P_SD);
    e.cfg   = (m_phase == P_CFG);
    e.flt   = (m_phase == P_FAULT || m_phase == P_RWAIT);
    e.lck   = (m_phase == P_LOCK);
    e.retry = RW'(m_retry);
    e.st    = 3'(m_phase);
    return e;
  endfunction

  // Apply the staged stimulus for one cycle and queue the expected outputs.
  task automatic tick();
    @(negedge clk_in);
    reset_in = r_rst;
    start_in = r_start;
    audio_locked_in = r_lock;
    nerror_in = r_nerr;
    ch_mask_in = r_mask;
    cfg_ack_in = r_ack;
    sb.push_back(model_step(r_rst, r_start, r_lock, r_nerr, r_mask, r_ack));
    r_ack = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the model is in phase p; a missed bound is a failure.
  task automatic wait_phase(input int p, input int lim);
    int n;
    n = 0;
    while (m_phase != p && n < lim) begin
      tick();
      n++;
    end
    n_cmp++;
    if (m_phase != p) begin
      n_fail++;
      $display("FAIL wait_phase: reached phase %0d, required %0d within %0d cycles", m_phase, p, lim);
    end
  endtask

  // Monitor: compare each registered output set against the queued expectation.
  initial begin
    obs_t got, exp_v;
    forever begin
      @(posedge clk_in);
      #2;
      if (sb.size() > 0) begin
        exp_v = sb.pop_front();
        got = '{nenable_out, nmute_out, send_config_out, fault_out, lockout_out, retry_cnt_out, state_out};
        n_cmp++;
        if (got !== exp_v) begin
          n_fail++;
          $display("FAIL outputs @%0t: got nen=%b nmute=%b cfg=%b flt=%b lck=%b retry=%0d st=%0d, required nen=%b nmute=%b cfg=%b flt=%b lck=%b retry=%0d st=%0d",
                   $time, got.nen, got.nmute, got.cfg, got.flt, got.lck, got.retry, got.st,
                   exp_v.nen, exp_v.nmute, exp_v.cfg, exp_v.flt, exp_v.lck, exp_v.retry, exp_v.st);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int drain;
    // Reset state
    r_rst = 1'b1;
    ticks(3);
    r_rst = 1'b0;
    ticks(2);

    // Nominal start, ack three cycles into SEND_CFG, then RUN
    r_start = 1'b1;
    wait_phase(P_CFG, 20);
    ticks(2);
    r_ack = 1'b1;
    tick();
    ticks(4);

    // Lock lost for 3 cycles in RUN
    r_lock = 1'b0;
    ticks(3);
    r_lock = 1'b1;
    ticks(3);

    // Fault on a masked channel is ignored, then unmasking it faults
    r_nerr = 2'b10;
    r_mask = 2'b10;
    ticks(4);
    r_mask = 2'b11;
    tick();
    r_nerr = 2'b11;

    // No acks: retries run out and the sequencer locks out
    wait_phase(P_LOCK, 200);
    ticks(3);
    r_start = 1'b0;
    ticks(3);

    // Orderly shutdown from RUN
    r_start = 1'b1;
    wait_phase(P_CFG, 20);
    r_ack = 1'b1;
    tick();
    ticks(3);
    r_start = 1'b0;
    ticks(8);

    // Fault and start drop on the same RUN cycle
    r_start = 1'b1;
    wait_phase(P_CFG, 20);
    r_ack = 1'b1;
    tick();
    ticks(2);
    r_start = 1'b0;
    r_nerr = 2'b01;
    tick();
    r_nerr = 2'b11;
    ticks(3);
    r_start = 1'b1;
    ticks(2);

    // Ack on the timeout cycle
    wait_phase(P_CFG, 40);
    while (m_phase == P_CFG && m_elapsed < CFG_C) tick();
    r_ack = 1'b1;
    tick();
    ticks(3);
    r_start = 1'b0;
    wait_phase(P_INIT, 20);

    // Reset in SEND_CFG
    r_start = 1'b1;
    wait_phase(P_CFG, 20);
    ticks(2);
    r_rst = 1'b1;
    tick();
    r_rst = 1'b0;
    ticks(2);

    // Randomised traffic
    for (int c = 0; c < 4000; c++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) r_start = ~r_start;
      r_lock = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < N_CH; i++) r_nerr[i] = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 49) == 0) r_mask = N_CH'($urandom);
      r_ack = r_start && ($urandom_range(0, 5) == 0);
      tick();
    end

    // Drain the scoreboard with a bounded wait
    drain = 0;
    while (sb.size() > 0 && drain < 10) begin
      @(negedge clk_in);
      drain++;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
